line_window_3x3: RTL and testbench
==================================

Name: line_window_3x3

Overview:
- Streaming 3x3 window generator; sits directly upstream of the 3x3 convolution stage.
- Accepts one 8-bit grayscale pixel per valid cycle in raster order. Buffers the two previous image lines in on-chip RAM.
- Emits a packed 72-bit 3x3 neighbourhood plus a valid strobe, in the exact format the convolution stage consumes.
- Only fully-populated windows are emitted (no padding), so the output is (IMG_W-2) x (IMG_H-2) windows per frame.

Parameters:
- IMG_W, 160, pixels per line; must be >= 3.
- IMG_H, 120, lines per frame; must be >= 3.
- CW, 8, column counter width; 2**CW >= IMG_W.
- RW, 8, row counter width; 2**RW >= IMG_H.

Ports:
- clk_in  input  1  single clock, all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- pixel_in  input  8  incoming pixel, raster order
- pixel_valid_in  input  1  pixel_in valid this cycle; may deassert any cycle (gaps allowed)
- pixel_data_out  output  72  packed 3x3 window
- pixel_data_valid_out  output  1  one-cycle strobe per emitted window
- frame_done_out  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Clock/reset: one clock (clk_in). Reset is synchronous and active-high (rst_in).
- Reset (rst_in=1 at posedge):
  - col=0, row=0; window registers = 0.
  - pixel_data_out=0, pixel_data_valid_out=0, frame_done_out=0.
  - Line RAM contents are not cleared; row gating makes them irrelevant.
- Accepted pixel at position (row r, col c), i.e. pixel_valid_in=1 at a posedge:
  - Read lb1[c] (line r-1) and lb0[c] (line r-2).
  - Write lb0[c] <= lb1[c] and lb1[c] <= pixel_in.
  - Shift the window left one column. New right column = {top lb0[c], mid lb1[c], bottom pixel_in}.
- Counters:
  - col increments per accepted pixel. At col=IMG_W-1 it wraps to 0 and row increments.
  - At row=IMG_H-1, col=IMG_W-1, row wraps to 0.
  - frame_done_out pulses 1 on the following cycle.
- Packing: byte i = pixel_data_out[i*8 +: 8], with i = 3*wr + wc.
  - wr=0 is the oldest line (r-2), wr=2 is the current line r.
  - wc=0 is the leftmost column (c-2).
  - Byte 8 is therefore the newest pixel; the window centre is (r-1, c-1).
- Emission:
  - If the accepted pixel has r>=2 and c>=2, pixel_data_valid_out=1 exactly one cycle later, with the completed window on pixel_data_out.
  - Otherwise pixel_data_valid_out=0.
- Latency: 1 cycle from the completing pixel to the window. No backpressure; the downstream stage accepts every strobe.
- Output hold: pixel_data_out holds its last value while pixel_data_valid_out=0.
- Idle cycles (pixel_valid_in=0): no state change; RAMs, window and counters hold.
- Line wrap: windows straddling a line boundary (c=0,1) are never emitted. Stale columns in the window registers are flushed naturally by c=2.
- Frame wrap: a new frame starts at row 0. Rows 0-1 of the new frame emit nothing and overwrite the line buffers before any use.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No output until row 2, col 2 of the restarted frame.
- Simultaneous rst_in and pixel_valid_in: reset wins and the pixel is dropped.
- RAM: dual-use, read and write of the same address in one cycle. The read must return the old data (read-before-write); implement with registered-address or explicit forwarding as needed.

Test Plan:
- Raster 1..12, IMG_W=4, IMG_H=3, continuous valid:
  - Exactly 2 windows, bytes 0..8 = {1,2,3,5,6,7,9,10,11}, then {2,3,4,6,7,8,10,11,12}.
  - frame_done_out pulses once, one cycle after pixel 12.
- Same stream with random 0-3 idle cycles between pixels: identical 2 windows, each 1 cycle after pixels 11 and 12 respectively; no spurious strobes.
- Two back-to-back frames (1..12, then 101..112): second frame emits {101,102,103,105,106,107,109,110,111} and {102,...,112}; no window mixes frames.
- Reset asserted after pixel 7, then raster 1..12 restarted: only the 2 expected windows; pixel_data_valid_out=0 during and after reset until then.
- Chained with downstream convolution stage (all-ones kernel), constant pixel 9, IMG_W=5, IMG_H=4: 3x2 = 6 outputs, each 9, valid 4 cycles after the completing pixel (1 here + 3 downstream).
- rst_in=1 with pixel_valid_in=1 on the same edge: counters stay 0 and the pixel is not counted (verified by subsequent window contents).

Source files
------------

// File: rtl/line_window_3x3_if.sv
// Pixel stream in, packed 3x3 window out; master is the upstream pixel source.
interface line_window_3x3_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid_in;
  logic [71:0] pixel_data_out;
  logic        pixel_data_valid_out;
  logic        frame_done_out;

  modport master (
    output pixel_in, pixel_valid_in,
    input  pixel_data_out, pixel_data_valid_out, frame_done_out
  );

  modport slave (
    input  pixel_in, pixel_valid_in,
    output pixel_data_out, pixel_data_valid_out, frame_done_out
  );
endinterface

// File: rtl/line_window_3x3.sv
// Raster 3x3 window generator over two line RAMs; window valid 1 cycle after the completing pixel.
// No backpressure: every accepted pixel is consumed and every window strobe is final.
module line_window_3x3 #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int CW    = 8,
  parameter int RW    = 8
) (
  input  logic            clk_in,
  input  logic            rst_in,
  line_window_3x3_if.slave pix
);

  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    win     [3][3];
  logic [7:0]    win_nxt [3][3];
  logic [71:0]   data_nxt;
  logic [7:0]    top_rd;
  logic [7:0]    mid_rd;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          emit;

  assign accept   = pix.pixel_valid_in;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = (row >= RW'(2)) && (col >= CW'(2));

  // Asynchronous read sees the pre-write contents, giving read-before-write on the same column.
  assign top_rd = lb0[col];
  assign mid_rd = lb1[col];

  always_comb begin
    data_nxt = '0;
    for (int wr = 0; wr < 3; wr++) begin
      win_nxt[wr][0] = win[wr][1];
      win_nxt[wr][1] = win[wr][2];
      win_nxt[wr][2] = 8'h00;
    end
    win_nxt[0][2] = top_rd;
    win_nxt[1][2] = mid_rd;
    win_nxt[2][2] = pix.pixel_in;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        data_nxt[(3*wr + wc)*8 +: 8] = win_nxt[wr][wc];
      end
    end
  end

  // Line RAMs carry no reset; row gating hides stale contents.
  always_ff @(posedge clk_in) begin
    if (!rst_in && accept) begin
      lb0[col] <= mid_rd;
      lb1[col] <= pix.pixel_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col                      <= '0;
      row                      <= '0;
      pix.pixel_data_out       <= '0;
      pix.pixel_data_valid_out <= 1'b0;
      pix.frame_done_out       <= 1'b0;
      for (int wr = 0; wr < 3; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          win[wr][wc] <= 8'h00;
        end
      end
    end else begin
      pix.pixel_data_valid_out <= 1'b0;
      pix.frame_done_out       <= 1'b0;
      if (accept) begin
        win <= win_nxt;
        if (emit) begin
          pix.pixel_data_out       <= data_nxt;
          pix.pixel_data_valid_out <= 1'b1;
        end
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row                <= '0;
            pix.frame_done_out <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3: scoreboard monitor on a 4x3 instance plus a 5x4 constant-frame instance.
module tb_line_window_3x3;

  localparam int W = 4;
  localparam int H = 3;

  localparam logic [71:0] WIN_A = 72'h0b0a09070605030201;
  localparam logic [71:0] WIN_B = 72'h0c0b0a080706040302;
  localparam logic [71:0] WIN_C = 72'h6f6e6d6b6a69676665;
  localparam logic [71:0] WIN_9 = {9{8'h09}};

  typedef struct {
    logic [71:0] dat;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_window_3x3_if pif ();
  line_window_3x3_if pif5 ();

  line_window_3x3 #(.IMG_W(4), .IMG_H(3), .CW(2), .RW(2)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .pix    (pif.slave)
  );

  line_window_3x3 #(.IMG_W(5), .IMG_H(4), .CW(3), .RW(2)) u_dut5 (
    .clk_in (clk),
    .rst_in (rst),
    .pix    (pif5.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  int   n_win    = 0;
  exp_t sb_q[$];
  time  fd_q[$];

  logic [7:0] fb [3][4];
  int         m_r = 0;
  int         m_c = 0;

  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w[(3*wr + wc)*8 +: 8] = fb[r-2+wr][c-2+wc];
      end
    end
    return w;
  endfunction

  // Output is sampled on the falling edge, half a period after the registering edge.
  always @(negedge clk) begin
    exp_t e;
    if (pif.pixel_data_valid_out) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_window got=%h at t=%0t", pif.pixel_data_out, $time);
      end else begin
        e = sb_q.pop_front();
        n_win++;
        if (pif.pixel_data_out !== e.dat || $time != e.t) begin
          failures++;
          $display("FAIL window got=%h at t=%0t expected=%h at t=%0t",
                   pif.pixel_data_out, $time, e.dat, e.t);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].t <= $time) begin
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_window got=none expected=%h at t=%0t", e.dat, e.t);
    end

    if (pif.frame_done_out) begin
      checks++;
      if (fd_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_frame_done got=1 at t=%0t expected=0", $time);
      end else if (fd_q.pop_front() != $time) begin
        failures++;
        $display("FAIL frame_done_time got pulse at t=%0t expected earlier/later", $time);
      end
    end else if (fd_q.size() > 0 && fd_q[0] <= $time) begin
      checks++;
      failures++;
      $display("FAIL missed_frame_done got=0 expected pulse at t=%0t", fd_q.pop_front());
    end
  end

  task automatic drive_px(input logic [7:0] p);
    @(negedge clk);
    pif.pixel_in       = p;
    pif.pixel_valid_in = 1'b1;
    @(posedge clk);
    fb[m_r][m_c] = p;
    if (m_r >= 2 && m_c >= 2) sb_q.push_back('{model_win(m_r, m_c), $time + 5});
    if (m_r == H-1 && m_c == W-1) fd_q.push_back($time + 5);
    if (m_c == W-1) begin
      m_c = 0;
      m_r = (m_r == H-1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pif.pixel_valid_in = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_reset(input logic with_px, input logic [7:0] p, input int n);
    @(negedge clk);
    rst                = 1'b1;
    pif.pixel_valid_in = with_px;
    pif.pixel_in       = p;
    repeat (n) @(posedge clk);
    m_r = 0;
    m_c = 0;
    #1;
    checks++;
    if (pif.pixel_data_valid_out !== 1'b0 || pif.pixel_data_out !== 72'h0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h expected valid=0 data=0",
               pif.pixel_data_valid_out, pif.pixel_data_out);
    end
    @(negedge clk);
    rst                = 1'b0;
    pif.pixel_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    pif.pixel_in        = 8'h00;
    pif.pixel_valid_in  = 1'b0;
    pif5.pixel_in       = 8'h00;
    pif5.pixel_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pif.pixel_data_out !== 72'h0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=0", pif.pixel_data_out);
    end
    checks++;
    if (pif.pixel_data_valid_out !== 1'b0 || pif.frame_done_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got valid=%b done=%b expected 0 0",
               pif.pixel_data_valid_out, pif.frame_done_out);
    end
    rst = 1'b0;
  endtask

  task automatic end_of_test(input string name, input int n0, input int want);
    idle(3);
    checks++;
    if (n_win - n0 !== want || sb_q.size() != 0 || fd_q.size() != 0) begin
      failures++;
      $display("FAIL %s windows got=%0d expected=%0d pending=%0d/%0d",
               name, n_win - n0, want, sb_q.size(), fd_q.size());
    end
  endtask

  task automatic test_basic();
    int n0 = n_win;
    for (int p = 1; p <= 12; p++) begin
      drive_px(8'(p));
      if (p == 11) begin
        #1;
        checks++;
        if (pif.pixel_data_valid_out !== 1'b1 || pif.pixel_data_out !== WIN_A) begin
          failures++;
          $display("FAIL basic_win1 got v=%b %h expected v=1 %h",
                   pif.pixel_data_valid_out, pif.pixel_data_out, WIN_A);
        end
      end
      if (p == 12) begin
        #1;
        checks++;
        if (pif.pixel_data_out !== WIN_B || pif.frame_done_out !== 1'b1) begin
          failures++;
          $display("FAIL basic_win2 got %h done=%b expected %h done=1",
                   pif.pixel_data_out, pif.frame_done_out, WIN_B);
        end
      end
    end
    @(negedge clk);
    pif.pixel_valid_in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pif.pixel_data_valid_out !== 1'b0 || pif.frame_done_out !== 1'b0 ||
        pif.pixel_data_out !== WIN_B) begin
      failures++;
      $display("FAIL basic_hold got v=%b done=%b %h expected v=0 done=0 %h",
               pif.pixel_data_valid_out, pif.frame_done_out, pif.pixel_data_out, WIN_B);
    end
    end_of_test("basic", n0, 2);
  endtask

  task automatic test_gaps();
    int n0 = n_win;
    for (int p = 1; p <= 12; p++) begin
      drive_px(8'(p));
      idle(int'($urandom_range(0, 3)));
    end
    end_of_test("gaps", n0, 2);
  endtask

  task automatic test_back_to_back();
    int n0 = n_win;
    for (int p = 1; p <= 12; p++) drive_px(8'(p));
    for (int p = 101; p <= 112; p++) begin
      drive_px(8'(p));
      if (p == 111) begin
        #1;
        checks++;
        if (pif.pixel_data_out !== WIN_C) begin
          failures++;
          $display("FAIL b2b_frame2_win1 got %h expected %h", pif.pixel_data_out, WIN_C);
        end
      end
    end
    end_of_test("back_to_back", n0, 4);
  endtask

  task automatic test_mid_reset();
    int n0 = n_win;
    for (int p = 1; p <= 7; p++) drive_px(8'(p));
    do_reset(1'b0, 8'h00, 2);
    for (int p = 1; p <= 12; p++) drive_px(8'(p));
    end_of_test("mid_reset", n0, 2);
  endtask

  task automatic test_reset_with_pixel();
    int n0 = n_win;
    do_reset(1'b1, 8'hee, 1);
    for (int p = 1; p <= 12; p++) begin
      drive_px(8'(p));
      if (p == 11) begin
        #1;
        checks++;
        if (pif.pixel_data_out !== WIN_A) begin
          failures++;
          $display("FAIL rst_px_dropped got %h expected %h", pif.pixel_data_out, WIN_A);
        end
      end
    end
    end_of_test("reset_with_pixel", n0, 2);
  endtask

  task automatic test_const_frame();
    int  cnt = 0;
    logic exp_v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        pif5.pixel_in       = 8'h09;
        pif5.pixel_valid_in = 1'b1;
        @(posedge clk);
        #1;
        exp_v = (r >= 2 && c >= 2);
        checks++;
        if (pif5.pixel_data_valid_out !== exp_v ||
            (exp_v && pif5.pixel_data_out !== WIN_9)) begin
          failures++;
          $display("FAIL const_r%0d_c%0d got v=%b %h expected v=%b %h",
                   r, c, pif5.pixel_data_valid_out, pif5.pixel_data_out, exp_v, WIN_9);
        end
        if (pif5.pixel_data_valid_out === 1'b1) cnt++;
      end
    end
    checks++;
    if (pif5.frame_done_out !== 1'b1 || cnt != 6) begin
      failures++;
      $display("FAIL const_frame got windows=%0d done=%b expected 6 done=1",
               cnt, pif5.frame_done_out);
    end
    @(negedge clk);
    pif5.pixel_valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_reset_with_pixel();
    test_const_frame();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
